// File: rtl/uart_tx_fifo.sv
// UART transmitter with a TX FIFO, a runtime baud divisor, optional parity and 1 or 2 stop bits.
// Frames go out LSB first, and queued words are sent back-to-back with no idle gap.
module uart_tx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 87,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_BITS-1:0]        data_in,
  input  logic [DIV_WIDTH-1:0]        div_in,
  input  logic                        div_load,
  input  logic                        ovf_clr,
  output logic                        tx,
  output logic                        busy,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = 4;
  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [BW-1:0]        LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]        LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0]        BIT_ONE   = BW'(1);
  localparam logic [PW-1:0]        DEPTH_CNT = PW'(FIFO_DEPTH);
  localparam logic                 PAR_INIT  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // FIFO storage and pointers (one extra wrap bit so full and empty differ)
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q;
  logic [PW-1:0]        rd_ptr_q;
  logic [PW-1:0]        wr_ptr_d;
  logic [PW-1:0]        rd_ptr_d;
  logic [PW-1:0]        count_d;
  logic [PW-1:0]        count_q;
  logic                 full_q;
  logic                 empty_q;
  logic                 ovf_q;

  // Divisor and transmit state
  logic [DIV_WIDTH-1:0] shadow_q;
  logic [DIV_WIDTH-1:0] active_q;
  logic [DIV_WIDTH-1:0] baud_q;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] head_w;
  logic                 par_q;
  logic [BW-1:0]        bit_q;
  state_t               state_q;
  logic                 tx_q;
  logic                 busy_q;

  logic                 push;
  logic                 pop;
  logic                 baud_done;
  logic                 last_stop;

  always_comb begin
    push      = wr_en && !full_q;
    baud_done = (baud_q == '0);
    last_stop = (state_q == ST_STOP) && baud_done && (bit_q == LAST_STOP);
    pop       = !empty_q && ((state_q == ST_IDLE) || last_stop);
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = wr_ptr_d - rd_ptr_d;
    div_eff   = (shadow_q == '0) ? DIV_ONE : shadow_q;
    head_w    = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      shadow_q <= DIV_RESET;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_CNT);
      empty_q  <= (count_d == '0);
      // A dropped write takes priority over a simultaneous clear
      if (wr_en && full_q) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
      if (div_load) begin
        shadow_q <= div_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      bit_q    <= '0;
      baud_q   <= '0;
      active_q <= DIV_RESET;
    end else if (pop) begin
      // Frame start: the divisor is frozen here for the whole frame
      state_q  <= ST_START;
      tx_q     <= 1'b0;
      busy_q   <= 1'b1;
      shift_q  <= head_w;
      par_q    <= (^head_w) ^ PAR_INIT;
      bit_q    <= '0;
      active_q <= div_eff;
      baud_q   <= div_eff - DIV_ONE;
    end else if (state_q != ST_IDLE) begin
      if (!baud_done) begin
        baud_q <= baud_q - DIV_ONE;
      end else begin
        baud_q <= active_q - DIV_ONE;
        case (state_q)
          ST_START: begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
          end
          ST_DATA: begin
            if (bit_q == LAST_DATA) begin
              bit_q <= '0;
              if (PARITY_EN != 0) begin
                state_q <= ST_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + BIT_ONE;
            end
          end
          ST_PARITY: begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
            bit_q   <= '0;
          end
          ST_STOP: begin
            if (bit_q == LAST_STOP) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + BIT_ONE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule
